// File: rtl/coreriscv_axi4_wrr_locking_arbiter_4_if.sv
// Request/grant bundle between four requesters, the weighted round-robin
// arbiter and the shared downstream channel.
interface coreriscv_axi4_wrr_locking_arbiter_4_if #(
    parameter int unsigned DATA_W = 64
);
    logic [3:0]             io_in_valid;
    logic [3:0]             io_in_ready;
    logic [3:0]             io_in_bits_multibeat;
    logic [3:0][DATA_W-1:0] io_in_bits_data;
    logic [3:0][1:0]        io_weight;
    logic                   io_out_ready;
    logic                   io_out_valid;
    logic [DATA_W-1:0]      io_out_bits_data;
    logic [1:0]             io_chosen;
    logic                   io_locked;

    // Environment side: requesters, weights and downstream ready
    modport master (
        output io_in_valid, io_in_bits_multibeat, io_in_bits_data, io_weight, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_data, io_chosen, io_locked
    );

    // Arbiter side
    modport slave (
        input  io_in_valid, io_in_bits_multibeat, io_in_bits_data, io_weight, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_data, io_chosen, io_locked
    );
endinterface

// File: rtl/coreriscv_axi4_wrr_locking_arbiter_4.sv
// Four-way weighted round-robin arbiter that locks the grant for the full
// length of a multibeat message; selection is combinational.
module coreriscv_axi4_wrr_locking_arbiter_4 #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8,
    parameter int unsigned CNT_W  = 3
) (
    input logic clk,
    input logic reset,
    coreriscv_axi4_wrr_locking_arbiter_4_if.slave bus
);
    localparam int unsigned NREQ = 4;

    logic [CNT_W-1:0]  beat_cnt;
    logic [1:0]        lock_id;
    logic [1:0]        last_grant;
    logic [1:0]        credit;

    logic [1:0]        rr_pick;
    logic [1:0]        chosen;
    logic              locked;
    logic              out_valid;
    logic              fire;
    logic              msg_done;
    logic [DATA_W-1:0] sel_data;
    logic [NREQ-1:0]   in_ready;

    assign locked = (beat_cnt != '0);

    // Rotating priority starting just after the previous winner
    always_comb begin
        logic [1:0] idx;
        rr_pick = last_grant + 2'd1;
        idx     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last_grant + 2'(i);
            if (bus.io_in_valid[idx]) rr_pick = idx;
        end
    end

    always_comb begin
        chosen = rr_pick;
        if (locked)
            chosen = lock_id;
        else if (bus.io_in_valid[last_grant] && credit != 2'd0)
            chosen = last_grant;
    end

    assign out_valid = bus.io_in_valid[chosen];
    assign sel_data  = bus.io_in_bits_data[chosen];
    assign fire      = bus.io_out_ready & out_valid;

    always_comb begin
        in_ready = '0;
        for (int n = 0; n < NREQ; n++)
            in_ready[n] = bus.io_out_ready && (chosen == 2'(n));
    end

    // A message ends on a single-beat first beat or on the last beat of a burst
    always_comb begin
        msg_done = 1'b0;
        if (fire) begin
            if (!locked)
                msg_done = !bus.io_in_bits_multibeat[chosen];
            else
                msg_done = (beat_cnt == CNT_W'(BEATS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt   <= '0;
            lock_id    <= 2'd0;
            last_grant <= 2'd3;
            credit     <= 2'd0;
        end else begin
            if (fire) begin
                if (!locked) begin
                    if (bus.io_in_bits_multibeat[chosen]) begin
                        beat_cnt <= CNT_W'(1);
                        lock_id  <= chosen;
                    end
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
            // Weight is sampled only when a new quantum starts
            if (msg_done) begin
                last_grant <= chosen;
                if (chosen != last_grant || credit == 2'd0)
                    credit <= bus.io_weight[chosen];
                else
                    credit <= credit - 2'd1;
            end
        end
    end

    assign bus.io_chosen        = chosen;
    assign bus.io_locked        = locked;
    assign bus.io_out_valid     = out_valid;
    assign bus.io_out_bits_data = sel_data;
    assign bus.io_in_ready      = in_ready;
endmodule

// File: tb/tb_coreriscv_axi4_wrr_locking_arbiter_4.sv
// Directed bench for the weighted round-robin locking arbiter.
module tb_coreriscv_axi4_wrr_locking_arbiter_4;
    localparam int unsigned DATA_W = 64;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    coreriscv_axi4_wrr_locking_arbiter_4_if #(.DATA_W(DATA_W)) bus ();

    coreriscv_axi4_wrr_locking_arbiter_4 #(
        .DATA_W(DATA_W), .BEATS(8), .CNT_W(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Expect requester ch to be granted and fire this cycle
    task automatic grant(input string tag, input logic [1:0] ch, input logic lk);
        logic [3:0] exp_rdy;
        #1;
        exp_rdy = 4'b0001 << ch;
        check({tag, ".chosen"}, 64'(bus.io_chosen), 64'(ch));
        check({tag, ".locked"}, 64'(bus.io_locked), 64'(lk));
        check({tag, ".valid"},  64'(bus.io_out_valid), 64'd1);
        check({tag, ".data"},   bus.io_out_bits_data, 64'hA0 + 64'(ch));
        check({tag, ".ready"},  64'(bus.io_in_ready), 64'(exp_rdy));
        cyc();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.io_in_valid          = 4'h0;
        bus.io_in_bits_multibeat = 4'h0;
        bus.io_out_ready         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.io_in_bits_data[i] = 64'hA0 + 64'(i);
            bus.io_weight[i]       = 2'd0;
        end
        cyc();

        // Reset state, nothing valid, downstream not ready
        do_reset();
        #1;
        check("rst.valid",  64'(bus.io_out_valid), 64'd0);
        check("rst.chosen", 64'(bus.io_chosen), 64'd0);
        check("rst.locked", 64'(bus.io_locked), 64'd0);
        check("rst.ready",  64'(bus.io_in_ready), 64'd0);
        cyc();

        // Plain round robin
        bus.io_in_valid  = 4'hF;
        bus.io_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) grant("rr", 2'(k), 1'b0);

        // Weight 2 on requester 0: three in a row before rotating
        do_reset();
        bus.io_weight[0] = 2'd2;
        begin
            logic [1:0] order [10];
            order = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
            for (int k = 0; k < 10; k++) grant("wrr", order[k], 1'b0);
        end
        bus.io_weight[0] = 2'd0;

        // Multibeat on requester 1 holds 8 fires
        do_reset();
        bus.io_in_bits_multibeat = 4'b0010;
        grant("mb.pre", 2'd0, 1'b0);
        grant("mb.b1", 2'd1, 1'b0);
        for (int k = 2; k <= 8; k++) grant("mb.bn", 2'd1, 1'b1);
        grant("mb.post2", 2'd2, 1'b0);
        grant("mb.post3", 2'd3, 1'b0);
        grant("mb.post0", 2'd0, 1'b0);

        // Locked requester drops valid mid-message
        do_reset();
        grant("gap.pre", 2'd0, 1'b0);
        grant("gap.b1", 2'd1, 1'b0);
        grant("gap.b2", 2'd1, 1'b1);
        grant("gap.b3", 2'd1, 1'b1);
        bus.io_in_valid = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("gap.valid",  64'(bus.io_out_valid), 64'd0);
            check("gap.chosen", 64'(bus.io_chosen), 64'd1);
            check("gap.locked", 64'(bus.io_locked), 64'd1);
            check("gap.ready",  64'(bus.io_in_ready), 64'b0010);
            cyc();
        end
        bus.io_in_valid = 4'hF;
        for (int k = 4; k <= 8; k++) grant("gap.bn", 2'd1, 1'b1);
        grant("gap.post", 2'd2, 1'b0);

        // Downstream stall freezes arbitration
        do_reset();
        bus.io_in_bits_multibeat = 4'h0;
        grant("stall.pre", 2'd0, 1'b0);
        bus.io_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall.chosen", 64'(bus.io_chosen), 64'd1);
            check("stall.valid",  64'(bus.io_out_valid), 64'd1);
            check("stall.ready",  64'(bus.io_in_ready), 64'd0);
            cyc();
        end
        bus.io_out_ready = 1'b1;
        grant("stall.r1", 2'd1, 1'b0);
        grant("stall.r2", 2'd2, 1'b0);

        // Reset during beat 5 of a locked message
        do_reset();
        bus.io_in_bits_multibeat = 4'b0010;
        bus.io_weight[3] = 2'd2;
        grant("mrst.pre", 2'd0, 1'b0);
        grant("mrst.b1", 2'd1, 1'b0);
        for (int k = 2; k <= 4; k++) grant("mrst.bn", 2'd1, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("mrst.locked", 64'(bus.io_locked), 64'd0);
        check("mrst.chosen", 64'(bus.io_chosen), 64'd0);
        cyc();
        grant("mrst.next", 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
